// File: rtl/exc_flush_ctrl_pkg.sv
// exc_flush_ctrl_pkg: shared trap codes, FSM states and event selectors
package exc_flush_ctrl_pkg;
  localparam logic [5:0] ECODE_INT = 6'h00;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, REDIRECT = 2'd2} state_e;
  typedef enum logic [1:0] {EV_NONE, EV_EXC, EV_ERTN, EV_INT} ev_kind_e;
  typedef enum logic {TGT_EENTRY, TGT_ERA} tgt_sel_e;
endpackage

// File: rtl/exc_prio.sv
// exc_prio: priority select of one trap event (exception > ertn > interrupt)
// en_i gates detection; kind_o/ecode_o/esubcode_o/tgt_sel_o describe the chosen event
module exc_prio
  import exc_flush_ctrl_pkg::*;
(
  input  logic       en_i,
  input  logic       wb_ex_i,
  input  logic [5:0] wb_ecode_i,
  input  logic [8:0] wb_esubcode_i,
  input  logic       wb_ertn_i,
  input  logic       int_pending_i,
  output ev_kind_e   kind_o,
  output logic [5:0] ecode_o,
  output logic [8:0] esubcode_o,
  output tgt_sel_e   tgt_sel_o
);
  assign kind_o = !en_i ? EV_NONE : wb_ex_i ? EV_EXC : wb_ertn_i ? EV_ERTN :
                  int_pending_i ? EV_INT : EV_NONE;
  assign ecode_o = kind_o == EV_EXC ? wb_ecode_i : ECODE_INT;
  assign esubcode_o = kind_o == EV_EXC ? wb_esubcode_i : '0;
  assign tgt_sel_o = kind_o == EV_ERTN ? TGT_ERA : TGT_EENTRY;
endmodule

// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: trap/ERTN commit, pipeline flush drain and IF redirect handshake
// WB inputs -> csr_ex_*/csr_ertn_commit (event cycle), wb_kill, pipe_flush,
// redirect_valid/redirect_pc/redirect_ready towards IF; resetn async active-low
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_ertn,
  input  logic        int_pending,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        csr_ex_commit,
  output logic [5:0]  csr_ex_ecode,
  output logic [8:0]  csr_ex_esubcode,
  output logic [31:0] csr_ex_pc,
  output logic        csr_ertn_commit,
  output logic        wb_kill,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rpc_q;
  logic        rv_q;
  ev_kind_e    kind;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  tgt_sel_e    tgt_sel;
  logic        trap;
  // resetn in the enable keeps the combinational commit outputs low during reset
  exc_prio u_prio (
    .en_i          (resetn && wb_valid && state_q == IDLE),
    .wb_ex_i       (wb_ex),
    .wb_ecode_i    (wb_ecode),
    .wb_esubcode_i (wb_esubcode),
    .wb_ertn_i     (wb_ertn),
    .int_pending_i (int_pending),
    .kind_o        (kind),
    .ecode_o       (ecode),
    .esubcode_o    (esubcode),
    .tgt_sel_o     (tgt_sel)
  );
  assign trap = kind == EV_EXC || kind == EV_INT;
  assign csr_ex_commit = trap;
  assign csr_ex_ecode = trap ? ecode : '0;
  assign csr_ex_esubcode = trap ? esubcode : '0;
  assign csr_ex_pc = trap ? wb_pc : '0;
  assign csr_ertn_commit = kind == EV_ERTN;
  // ERTN retires; anything arriving while busy is squashed
  assign wb_kill = trap || (wb_valid && state_q != IDLE);
  assign pipe_flush = kind != EV_NONE || state_q == DRAIN;
  assign redirect_valid = rv_q;
  assign redirect_pc = rpc_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rpc_q <= '0;
      rv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (kind != EV_NONE) begin
          state_q <= DRAIN;
          cnt_q <= 4'(FLUSH_CYCLES - 1);
          rpc_q <= tgt_sel == TGT_ERA ? csr_era : csr_eentry;
        end
        DRAIN: if (cnt_q == '0) begin
          state_q <= REDIRECT;
          rv_q <= 1'b1;
        end else cnt_q <= cnt_q - 4'd1;
        REDIRECT: if (redirect_ready) begin
          state_q <= IDLE;
          rv_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb_exc_flush_ctrl: directed plan plus random traffic against an elapsed-cycle reference model
module tb_exc_flush_ctrl;
  localparam int F = 2;
  logic clk = 1'b0;
  logic resetn, wb_valid, wb_ex, wb_ertn, int_pending, redirect_ready;
  logic [31:0] wb_pc, csr_eentry, csr_era;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic csr_ex_commit, csr_ertn_commit, wb_kill, pipe_flush, redirect_valid;
  logic [5:0] csr_ex_ecode;
  logic [8:0] csr_ex_esubcode;
  logic [31:0] csr_ex_pc, redirect_pc;
  int ncmp = 0;
  int nfail = 0;
  int since = -1;
  logic [31:0] m_tgt = '0;
  exc_flush_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ertn(wb_ertn),
    .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .csr_ex_commit(csr_ex_commit), .csr_ex_ecode(csr_ex_ecode),
    .csr_ex_esubcode(csr_ex_esubcode), .csr_ex_pc(csr_ex_pc),
    .csr_ertn_commit(csr_ertn_commit), .wb_kill(wb_kill), .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // since = cycles elapsed since the accepted event (-1 when idle)
  task automatic check_all();
    logic idle, exc, ertn;
    idle = resetn && since < 0;
    exc = idle && wb_valid && (wb_ex || (!wb_ertn && int_pending));
    ertn = idle && wb_valid && !wb_ex && wb_ertn;
    chk("ex_commit", 32'(csr_ex_commit), 32'(exc));
    chk("ex_ecode", 32'(csr_ex_ecode), exc && wb_ex ? 32'(wb_ecode) : 32'd0);
    chk("ex_esub", 32'(csr_ex_esubcode), exc && wb_ex ? 32'(wb_esubcode) : 32'd0);
    chk("ex_pc", csr_ex_pc, exc ? wb_pc : 32'd0);
    chk("ertn_commit", 32'(csr_ertn_commit), 32'(ertn));
    chk("wb_kill", 32'(wb_kill), 32'(exc || (resetn && since >= 0 && wb_valid)));
    chk("pipe_flush", 32'(pipe_flush), 32'(exc || ertn || (resetn && since >= 1 && since <= F)));
    chk("redirect_valid", 32'(redirect_valid), 32'(resetn && since > F));
    chk("redirect_pc", redirect_pc, m_tgt);
  endtask
  task automatic model_edge();
    if (!resetn) begin
      since = -1;
      m_tgt = '0;
    end else if (since < 0) begin
      if (wb_valid && (wb_ex || wb_ertn || int_pending)) begin
        since = 1;
        m_tgt = (!wb_ex && wb_ertn) ? csr_era : csr_eentry;
      end
    end else if (since <= F) since++;
    else if (redirect_ready) since = -1;
  endtask
  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic clr();
    wb_valid = 0;
    wb_ex = 0;
    wb_ertn = 0;
    int_pending = 0;
    wb_ecode = '0;
    wb_esubcode = '0;
  endtask
  initial begin
    resetn = 0;
    clr();
    redirect_ready = 0;
    wb_pc = '0;
    csr_eentry = '0;
    csr_era = '0;
    repeat (2) cyc();
    resetn = 1;
    // syscall with stalled redirect
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; wb_pc = 32'h1c000010;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c000014;
    #1;
    chk("sys_commit", 32'(csr_ex_commit), 32'd1);
    chk("sys_kill", 32'(wb_kill), 32'd1);
    chk("sys_pc", csr_ex_pc, 32'h1c000010);
    cyc();
    clr();
    repeat (F) cyc();
    chk("sys_rv", 32'(redirect_valid), 32'd1);
    chk("sys_rpc", redirect_pc, 32'h1c008000);
    repeat (3) cyc();
    chk("sys_rpc_stable", redirect_pc, 32'h1c008000);
    redirect_ready = 1;
    cyc();
    redirect_ready = 0;
    chk("sys_idle", 32'(redirect_valid), 32'd0);
    cyc();
    // ERTN
    wb_valid = 1; wb_ertn = 1; redirect_ready = 1;
    #1;
    chk("ertn_commit_d", 32'(csr_ertn_commit), 32'd1);
    chk("ertn_kill", 32'(wb_kill), 32'd0);
    cyc();
    clr();
    repeat (F) cyc();
    chk("ertn_rv", 32'(redirect_valid), 32'd1);
    chk("ertn_rpc", redirect_pc, 32'h1c000014);
    cyc();
    chk("ertn_idle", 32'(redirect_valid), 32'd0);
    // exception beats interrupt; interrupt held through busy window
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; int_pending = 1; redirect_ready = 0;
    #1;
    chk("prio_ecode", 32'(csr_ex_ecode), 32'h0B);
    cyc();
    wb_valid = 0; wb_ex = 0;
    repeat (F + 3) cyc();
    redirect_ready = 1;
    cyc();
    // interrupt gated by wb_valid
    repeat (4) cyc();
    wb_valid = 1; wb_pc = 32'h1c000020;
    #1;
    chk("int_commit", 32'(csr_ex_commit), 32'd1);
    chk("int_ecode", 32'(csr_ex_ecode), 32'd0);
    chk("int_pc", csr_ex_pc, 32'h1c000020);
    cyc();
    clr();
    repeat (F + 2) cyc();
    // event injected during DRAIN is blocked
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; wb_pc = 32'h1c000030;
    csr_eentry = 32'h1c008100; redirect_ready = 0;
    cyc();
    csr_eentry = 32'h1c00dead; wb_pc = 32'h1c000034;
    #1;
    chk("blk_commit", 32'(csr_ex_commit), 32'd0);
    chk("blk_kill", 32'(wb_kill), 32'd1);
    repeat (F) cyc();
    clr();
    chk("blk_rpc", redirect_pc, 32'h1c008100);
    cyc();
    // asynchronous reset mid-REDIRECT
    #2 resetn = 0;
    #1;
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_pf", 32'(pipe_flush), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    since = -1;
    m_tgt = '0;
    cyc();
    resetn = 1;
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h0B; wb_pc = 32'h1c000040;
    csr_eentry = 32'h1c008000; redirect_ready = 1;
    #1;
    chk("post_rst_commit", 32'(csr_ex_commit), 32'd1);
    cyc();
    clr();
    repeat (F) cyc();
    chk("post_rst_rpc", redirect_pc, 32'h1c008000);
    cyc();
    // random traffic
    repeat (400) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_ex = $urandom_range(0, 4) == 0;
      wb_ertn = $urandom_range(0, 4) == 0;
      int_pending = $urandom_range(0, 3) == 0;
      wb_ecode = 6'($urandom);
      wb_esubcode = 9'($urandom);
      wb_pc = $urandom;
      csr_eentry = $urandom;
      csr_era = $urandom;
      redirect_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/exc_flush_ctrl.md
# exc_flush_ctrl

Exception, interrupt and ERTN flush controller for the 5-stage LoongArch pipeline. It sits beside the WB stage, between WB, the CSR file and IF. It selects one trap event per committing instruction and issues the CSR commit pulse. It then holds a pipeline-wide flush for a fixed drain window and hands IF a redirect PC over a valid/ready handshake. Any further WB events during the drain and redirect window are blocked.

## Interface
Parameters:
- FLUSH_CYCLES, 1: cycles in DRAIN after the event cycle; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- wb_valid  in  1  WB holds a valid instruction this cycle
- wb_pc  in  32  PC of the WB instruction
- wb_ex  in  1  synchronous exception flagged on the WB instruction
- wb_ecode  in  6  ecode for wb_ex
- wb_esubcode  in  9  esubcode for wb_ex
- wb_ertn  in  1  WB instruction is ERTN
- int_pending  in  1  CSR has an enabled pending interrupt (CRMD.IE already applied)
- csr_eentry  in  32  current EENTRY
- csr_era  in  32  current ERA
- csr_ex_commit  out  1  one-cycle pulse; CSR performs trap entry
- csr_ex_ecode  out  6  ecode for trap entry
- csr_ex_esubcode  out  9  esubcode for trap entry
- csr_ex_pc  out  32  value CSR writes into ERA
- csr_ertn_commit  out  1  one-cycle pulse; CSR restores PRMD into CRMD
- wb_kill  out  1  suppresses GPR and CSR writes of the current WB instruction
- pipe_flush  out  1  invalidates IF/ID/EX/MEM contents
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  32  fetch target
- redirect_ready  in  1  IF accepts the redirect

## Operation
The controller has three states: IDLE, DRAIN and REDIRECT.

Event detection, IDLE only, when wb_valid=1. Priority is wb_ex > wb_ertn > int_pending.
- **Exception:** csr_ex_commit=1, ecode and esubcode from WB, csr_ex_pc=wb_pc. Target latched from csr_eentry.
- **ERTN:** csr_ertn_commit=1. Target latched from csr_era.
- **Interrupt:** csr_ex_commit=1, ecode=ECODE_INT (0x00), esubcode=0, csr_ex_pc=wb_pc. Target latched from csr_eentry.
- In every case, in the event cycle: wb_kill=1 (exception and interrupt only; ERTN itself retires), pipe_flush=1, and the next state is DRAIN.
- The drain counter loads FLUSH_CYCLES-1.
- An interrupt is never taken while wb_valid=0.

State transitions:
- **DRAIN:** pipe_flush=1. The counter decrements each cycle. At count 0 the next state is REDIRECT.
- **REDIRECT:** redirect_valid=1 and pipe_flush=0. redirect_pc is stable while redirect_valid=1. On redirect_valid & redirect_ready the next state is IDLE.

Events outside IDLE:
- Events are ignored in DRAIN and REDIRECT, with no commit pulse.
- If wb_valid=1 in DRAIN or REDIRECT, wb_kill=1.

Output timing:
- csr_ex_* and csr_ertn_commit are combinational from the WB inputs in the event cycle. The CSR file updates at that cycle's edge.
- All outputs are 0 outside the event cycle, except pipe_flush, redirect_valid, redirect_pc and wb_kill as defined above.

Reset:
- Asynchronous, at any point: state=IDLE, counter=0, redirect_pc=0.
- All outputs are 0 while reset is asserted.
- Reset during REDIRECT drops the request without a handshake.

## Timing
- Event at cycle T: commit pulse and pipe_flush at T; pipe_flush held T..T+FLUSH_CYCLES.
- redirect_valid first asserted at T+FLUSH_CYCLES+1.
- Minimum event-to-IDLE time is FLUSH_CYCLES+2 cycles, with redirect_ready=1.
- redirect_ready has no combinational path to any output other than the next-state logic.

## Structure
- defines.vh holds:
  - ECODE_INT (6'h00), next to the existing ECODE_SYS (6'h0B).
  - The state encoding: IDLE=2'd0, DRAIN=2'd1, REDIRECT=2'd2.
- Sub-module exc_prio: combinational priority select of {kind, ecode, esubcode, target_sel} from wb_ex, wb_ertn and int_pending.
- The top level holds the FSM, the counter, and the redirect_pc register.

## Test plan
- **Syscall:** FLUSH_CYCLES=2. wb_valid=1, wb_ex=1, ecode=0x0B, wb_pc=0x1c000010, csr_eentry=0x1c008000 at T.
  - csr_ex_commit=1, csr_ex_pc=0x1c000010, wb_kill=1 at T.
  - pipe_flush at T..T+2.
  - redirect_valid at T+3 with pc 0x1c008000.
  - redirect_ready held 0 for 3 cycles: redirect_pc remains stable. IDLE follows the accepting cycle.
- **ERTN:** wb_ertn=1, csr_era=0x1c000014, redirect_ready=1.
  - csr_ertn_commit pulse, wb_kill=0.
  - redirect_pc=0x1c000014, back in IDLE at T+FLUSH_CYCLES+2.
- **Priority:** wb_ex=1 (ecode 0x0B) and int_pending=1 in the same cycle.
  - Exactly one csr_ex_commit with ecode 0x0B. No second trap while int_pending stays 1 through DRAIN/REDIRECT.
- **Interrupt gating:** int_pending=1 with wb_valid=0 for 4 cycles → no commit.
  - wb_valid=1, wb_pc=0x1c000020 → commit with ecode 0x00, esubcode 0, csr_ex_pc=0x1c000020.
- **Blocked event:** wb_valid=1, wb_ex=1 injected during DRAIN → no commit pulse, wb_kill=1, redirect_pc unchanged.
- **Reset:** resetn low mid-REDIRECT.
  - redirect_valid and pipe_flush fall without waiting for a clock edge.
  - After release, state is IDLE and a new syscall is handled normally.
